// File: rtl/touch_coord_filter_pkg.sv
// touch_pkg: shared definitions for the touchscreen coordinate filter.
//   - state_e       : sample-burst FSM states
//   - ADDR_*        : Avalon-MM word addresses of the register map
//   - STAT_*        : bit positions inside the status register
package touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_XPIX   = 2'd1;
  localparam logic [1:0] ADDR_YPIX   = 2'd2;
  localparam logic [1:0] ADDR_AVG    = 2'd3;

  localparam int unsigned STAT_NEW     = 0;
  localparam int unsigned STAT_TOUCHED = 1;
  localparam int unsigned STAT_IRQEN   = 2;

endpackage

// File: rtl/touch_axis_scale.sv
// touch_axis_scale: three-stage pipe turning one axis accumulator into a
// clamped pixel coordinate.
//   stage 1 (start_i): avg = acc >> AVG_LOG2, diff = avg - MIN (signed 13 bit)
//   stage 2          : product = diff * GAIN (GAIN is Q0.12)
//   stage 3          : pix = product >>> 12, clamped to 0 .. RES-1
// Ports:
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   start_i      : one-cycle pulse, acc_i holds the completed burst sum
//   acc_i        : 16-bit burst accumulator
//   avg_o        : last averaged raw value (12 bit)
//   done_o       : high the cycle before pix_o takes its new value
//   pix_o        : registered clamped pixel coordinate
module touch_axis_scale #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int          MIN      = 200,
  parameter int          GAIN     = 886,
  parameter int          RES      = 800
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        start_i,
  input  logic [15:0] acc_i,
  output logic [11:0] avg_o,
  output logic        done_o,
  output logic [10:0] pix_o
);

  localparam logic signed [12:0] MIN_S   = 13'(MIN);
  localparam logic signed [25:0] GAIN_S  = 26'(GAIN);
  localparam logic signed [25:0] RES_S   = 26'(RES);
  localparam logic        [10:0] PIX_MAX = 11'(RES - 1);

  logic        [15:0] avg_full;
  logic signed [12:0] diff_d, diff_q;
  logic signed [25:0] prod_d, prod_q, pix_full;
  logic        [10:0] pix_d, pix_q;
  logic        [11:0] avg_q;
  logic               v1_q, v2_q;
  logic               unused_avg;

  always_comb begin
    // A full burst of 12-bit samples shifted by AVG_LOG2 always fits 12 bits.
    avg_full = acc_i >> AVG_LOG2;
    diff_d   = $signed({1'b0, avg_full[11:0]}) - MIN_S;
    prod_d   = 26'(diff_q) * GAIN_S;
    pix_full = prod_q >>> 12;
    if (pix_full < 26'sd0) begin
      pix_d = '0;
    end else if (pix_full >= RES_S) begin
      pix_d = PIX_MAX;
    end else begin
      pix_d = pix_full[10:0];
    end
  end

  assign unused_avg = |avg_full[15:12];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      avg_q  <= '0;
      diff_q <= '0;
      prod_q <= '0;
      pix_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= start_i;
      v2_q <= v1_q;
      if (start_i) begin
        avg_q  <= avg_full[11:0];
        diff_q <= diff_d;
      end
      if (v1_q) prod_q <= prod_d;
      if (v2_q) pix_q  <= pix_d;
    end
  end

  assign avg_o  = avg_q;
  assign done_o = v2_q;
  assign pix_o  = pix_q;

endmodule

// File: rtl/touch_coord_filter.sv
// touch_coord_filter: averages bursts of 2^AVG_LOG2 raw touchscreen samples,
// maps them to clamped LCD pixel coordinates, detects pen release and exposes
// the result through a small Avalon-MM slave with a level interrupt.
// Optional feature: define TOUCH_OUTLIER_REJECT_EN to restart a burst when a
// sample differs from the burst's first sample by more than JITTER_MAX.
// Ports:
//   iCLK, iRST_n          : clock, asynchronous active-low reset
//   iSAMPLE_VALID         : one-cycle strobe qualifying iX_RAW / iY_RAW
//   iX_RAW, iY_RAW        : 12-bit raw ADC samples
//   iPENIRQ_n             : asynchronous pen-down, active low
//   iAVS_ADDRESS/READ/WRITE/WRITEDATA, oAVS_READDATA : Avalon-MM slave,
//                           read latency 1 (0 status, 1 X, 2 Y, 3 averages)
//   oIRQ                  : new_flag & irq_en, registered
//   oX_PIX, oY_PIX        : last reported pixel coordinates
//   oVALID                : one-cycle pulse per report
//   oTOUCHED              : pen considered down
module touch_coord_filter
  import touch_pkg::*;
#(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int          X_MIN       = 200,
  parameter int          Y_MIN       = 300,
  parameter int          X_GAIN      = 886,
  parameter int          Y_GAIN      = 562,
  parameter int          H_RES       = 800,
  parameter int          V_RES       = 480,
  parameter int unsigned RELEASE_CYC = 50000,
  parameter int unsigned JITTER_MAX  = 64
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSAMPLE_VALID,
  input  logic [11:0] iX_RAW,
  input  logic [11:0] iY_RAW,
  input  logic        iPENIRQ_n,
  input  logic [1:0]  iAVS_ADDRESS,
  input  logic        iAVS_READ,
  input  logic        iAVS_WRITE,
  input  logic [31:0] iAVS_WRITEDATA,
  output logic [31:0] oAVS_READDATA,
  output logic        oIRQ,
  output logic [10:0] oX_PIX,
  output logic [10:0] oY_PIX,
  output logic        oVALID,
  output logic        oTOUCHED
);

  localparam logic [4:0]        NSAMP    = 5'(1 << AVG_LOG2);
  localparam int unsigned       RW       = $clog2(RELEASE_CYC + 1);
  localparam logic [RW-1:0]     REL_LAST = RW'(RELEASE_CYC - 1);
  localparam logic [RW-1:0]     REL_FULL = RW'(RELEASE_CYC);

  state_e        state_q;
  logic [15:0]   acc_x_q, acc_y_q;
  logic [4:0]    cnt_q;
  logic          start_q;
  logic          pen_s1_q, pen_s2_q;
  logic [RW-1:0] rel_cnt_q;
  logic          rel_pend_q;
  logic          touched_q, valid_q, irq_q;
  logic          new_flag_q, new_flag_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   rdata_q, rdata_d, status_w;
  logic [11:0]   x_avg, y_avg;
  logic [10:0]   x_pix, y_pix;
  logic          x_done, y_done;
  logic          rel_hit, rel_apply, rpt_done, burst_restart;
  logic          unused_wdata;

  // Pen input synchroniser; high on pen_s2_q means pen up.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pen_s1_q <= 1'b0;
      pen_s2_q <= 1'b0;
    end else begin
      pen_s1_q <= iPENIRQ_n;
      pen_s2_q <= pen_s1_q;
    end
  end

  // Saturating pen-up run counter; the event fires once per up period.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rel_cnt_q <= '0;
    end else if (!pen_s2_q) begin
      rel_cnt_q <= '0;
    end else if (rel_cnt_q != REL_FULL) begin
      rel_cnt_q <= rel_cnt_q + 1'b1;
    end
  end

  assign rel_hit   = pen_s2_q && (rel_cnt_q == REL_LAST);
  assign rpt_done  = (state_q == ST_SCALE) && x_done && y_done;
  // A release seen during SCALE is held until the report has gone out.
  assign rel_apply = (state_q != ST_SCALE) && (rel_hit || rel_pend_q);

`ifdef TOUCH_OUTLIER_REJECT_EN
  localparam logic [11:0] JIT = 12'(JITTER_MAX);
  logic [11:0] first_x_q, first_y_q, dx, dy;
  always_comb begin
    dx = (iX_RAW >= first_x_q) ? (iX_RAW - first_x_q) : (first_x_q - iX_RAW);
    dy = (iY_RAW >= first_y_q) ? (iY_RAW - first_y_q) : (first_y_q - iY_RAW);
    burst_restart = (state_q == ST_IDLE) ||
                    ((state_q == ST_ACCUM) && ((dx > JIT) || (dy > JIT)));
  end
`else
  logic unused_jitter;
  assign unused_jitter = (JITTER_MAX != 0);
  assign burst_restart = (state_q == ST_IDLE);
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      rel_pend_q <= 1'b0;
      touched_q  <= 1'b0;
      valid_q    <= 1'b0;
`ifdef TOUCH_OUTLIER_REJECT_EN
      first_x_q  <= '0;
      first_y_q  <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      if (state_q == ST_SCALE) begin
        if (rel_hit) rel_pend_q <= 1'b1;
        if (rpt_done) begin
          state_q   <= ST_IDLE;
          valid_q   <= 1'b1;
          touched_q <= 1'b1;
        end
      end else if (rel_apply) begin
        rel_pend_q <= 1'b0;
        touched_q  <= 1'b0;
        state_q    <= ST_IDLE;
        acc_x_q    <= '0;
        acc_y_q    <= '0;
        cnt_q      <= '0;
      end else if (iSAMPLE_VALID) begin
        if (burst_restart) begin
          acc_x_q <= {4'b0, iX_RAW};
          acc_y_q <= {4'b0, iY_RAW};
          cnt_q   <= 5'd1;
`ifdef TOUCH_OUTLIER_REJECT_EN
          first_x_q <= iX_RAW;
          first_y_q <= iY_RAW;
`endif
          if (NSAMP == 5'd1) begin
            state_q <= ST_SCALE;
            start_q <= 1'b1;
          end else begin
            state_q <= ST_ACCUM;
          end
        end else begin
          acc_x_q <= acc_x_q + {4'b0, iX_RAW};
          acc_y_q <= acc_y_q + {4'b0, iY_RAW};
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q + 5'd1 == NSAMP) begin
            state_q <= ST_SCALE;
            start_q <= 1'b1;
          end
        end
      end
    end
  end

  touch_axis_scale #(
    .AVG_LOG2 (AVG_LOG2),
    .MIN      (X_MIN),
    .GAIN     (X_GAIN),
    .RES      (H_RES)
  ) u_scale_x (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .start_i (start_q),
    .acc_i   (acc_x_q),
    .avg_o   (x_avg),
    .done_o  (x_done),
    .pix_o   (x_pix)
  );

  touch_axis_scale #(
    .AVG_LOG2 (AVG_LOG2),
    .MIN      (Y_MIN),
    .GAIN     (Y_GAIN),
    .RES      (V_RES)
  ) u_scale_y (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .start_i (start_q),
    .acc_i   (acc_y_q),
    .avg_o   (y_avg),
    .done_o  (y_done),
    .pix_o   (y_pix)
  );

  always_comb begin
    status_w               = '0;
    status_w[STAT_NEW]     = new_flag_q;
    status_w[STAT_TOUCHED] = touched_q;
    status_w[STAT_IRQEN]   = irq_en_q;

    case (iAVS_ADDRESS)
      ADDR_STATUS: rdata_d = status_w;
      ADDR_XPIX:   rdata_d = {21'b0, x_pix};
      ADDR_YPIX:   rdata_d = {21'b0, y_pix};
      default:     rdata_d = {4'b0, y_avg, 4'b0, x_avg};
    endcase

    // Set beats a read-clear in the same cycle.
    new_flag_d = new_flag_q;
    if (iAVS_READ && (iAVS_ADDRESS == ADDR_STATUS)) new_flag_d = 1'b0;
    if (rpt_done || rel_apply) new_flag_d = 1'b1;

    irq_en_d = irq_en_q;
    if (iAVS_WRITE && (iAVS_ADDRESS == ADDR_STATUS)) irq_en_d = iAVS_WRITEDATA[STAT_IRQEN];
  end

  assign unused_wdata = ^{iAVS_WRITEDATA[31:3], iAVS_WRITEDATA[1:0]};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      new_flag_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      new_flag_q <= new_flag_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= new_flag_q & irq_en_q;
      if (iAVS_READ) rdata_q <= rdata_d;
    end
  end

  assign oAVS_READDATA = rdata_q;
  assign oIRQ          = irq_q;
  assign oX_PIX        = x_pix;
  assign oY_PIX        = y_pix;
  assign oVALID        = valid_q;
  assign oTOUCHED      = touched_q;

endmodule

// File: tb/tb_touch_coord_filter.sv
// Self-checking bench for touch_coord_filter. A sample-queue / event-time
// model predicts every output each cycle; directed tests add literal checks.
module tb_touch_coord_filter;

  localparam int REL = 2000;
  localparam int N   = 4;
  localparam int JIT = 64;

  logic        iCLK, iRST_n, iSAMPLE_VALID, iPENIRQ_n;
  logic [11:0] iX_RAW, iY_RAW;
  logic [1:0]  iAVS_ADDRESS;
  logic        iAVS_READ, iAVS_WRITE;
  logic [31:0] iAVS_WRITEDATA, oAVS_READDATA;
  logic        oIRQ, oVALID, oTOUCHED;
  logic [10:0] oX_PIX, oY_PIX;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  touch_coord_filter #(
    .AVG_LOG2    (2),
    .RELEASE_CYC (REL),
    .JITTER_MAX  (JIT)
  ) dut (
    .iCLK           (iCLK),
    .iRST_n         (iRST_n),
    .iSAMPLE_VALID  (iSAMPLE_VALID),
    .iX_RAW         (iX_RAW),
    .iY_RAW         (iY_RAW),
    .iPENIRQ_n      (iPENIRQ_n),
    .iAVS_ADDRESS   (iAVS_ADDRESS),
    .iAVS_READ      (iAVS_READ),
    .iAVS_WRITE     (iAVS_WRITE),
    .iAVS_WRITEDATA (iAVS_WRITEDATA),
    .oAVS_READDATA  (oAVS_READDATA),
    .oIRQ           (oIRQ),
    .oX_PIX         (oX_PIX),
    .oY_PIX         (oY_PIX),
    .oVALID         (oVALID),
    .oTOUCHED       (oTOUCHED)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int map_pix(int avg, int mn, int gain, int res);
    int p;
    if (avg < mn) return 0;
    p = (avg - mn) * gain / 4096;
    if (p > res - 1) p = res - 1;
    return p;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  int   q_x[$], q_y[$];
  int   m_n = 0, m_scale_at = 0, m_rel_due = -1, m_run = 0;
  bit   m_scaling = 0, m_d1 = 0, m_d2 = 0;
  bit   m_touched = 0, m_nf = 0, m_ie = 0;
  int   m_px = 0, m_py = 0, m_ax = 0, m_ay = 0;
  int   r_px, r_py, r_ax, r_ay;
  bit   exp_valid = 0, exp_irq = 0;
  logic [31:0] exp_rd = '0;

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      q_x.delete(); q_y.delete();
      m_scaling = 0; m_rel_due = -1; m_run = 0; m_d1 = 0; m_d2 = 0;
      m_touched = 0; m_nf = 0; m_ie = 0;
      m_px = 0; m_py = 0; m_ax = 0; m_ay = 0;
      exp_valid = 0; exp_irq = 0; exp_rd = '0;
    end else begin
      bit busy, fire, nfset;
      int sx, sy;
      m_n++;
      exp_irq = m_nf && m_ie;
      if (iAVS_READ) begin
        case (iAVS_ADDRESS)
          2'd0:    exp_rd = {29'b0, m_ie, m_touched, m_nf};
          2'd1:    exp_rd = 32'(m_px);
          2'd2:    exp_rd = 32'(m_py);
          default: exp_rd = (32'(m_ay) << 16) | 32'(m_ax);
        endcase
      end
      busy = m_scaling;
      fire = 0;
      if (m_d2) begin
        m_run++;
        if (m_run == REL) fire = 1;
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = iPENIRQ_n;
      if (fire) m_rel_due = busy ? m_scale_at + 1 : m_n;
      exp_valid = 0;
      nfset = 0;
      if (busy && m_n == m_scale_at) begin
        m_px = r_px; m_py = r_py; m_ax = r_ax; m_ay = r_ay;
        exp_valid = 1; m_touched = 1; nfset = 1; m_scaling = 0;
      end
      if (m_rel_due == m_n) begin
        m_touched = 0; nfset = 1; m_rel_due = -1;
        q_x.delete(); q_y.delete();
      end else if (iSAMPLE_VALID && !busy) begin
`ifdef TOUCH_OUTLIER_REJECT_EN
        if (q_x.size() > 0 &&
            (iabs(int'(iX_RAW) - q_x[0]) > JIT || iabs(int'(iY_RAW) - q_y[0]) > JIT)) begin
          q_x.delete(); q_y.delete();
        end
`endif
        q_x.push_back(int'(iX_RAW));
        q_y.push_back(int'(iY_RAW));
        if (q_x.size() == N) begin
          sx = 0; sy = 0;
          foreach (q_x[i]) begin sx += q_x[i]; sy += q_y[i]; end
          r_ax = sx / N; r_ay = sy / N;
          r_px = map_pix(r_ax, 200, 886, 800);
          r_py = map_pix(r_ay, 300, 562, 480);
          m_scale_at = m_n + 3;
          m_scaling = 1;
          q_x.delete(); q_y.delete();
        end
      end
      if (iAVS_READ && iAVS_ADDRESS == 2'd0) m_nf = 0;
      if (nfset) m_nf = 1;
      if (iAVS_WRITE && iAVS_ADDRESS == 2'd0) m_ie = iAVS_WRITEDATA[2];
    end
  end

  always @(negedge iCLK) begin
    if (oVALID) vcount++;
    check("valid",   32'(oVALID),   32'(exp_valid));
    check("x_pix",   32'(oX_PIX),   32'(m_px));
    check("y_pix",   32'(oY_PIX),   32'(m_py));
    check("touched", 32'(oTOUCHED), 32'(m_touched));
    check("irq",     32'(oIRQ),     32'(exp_irq));
    check("rdata",   oAVS_READDATA, exp_rd);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge iCLK);
    #1;
  endtask

  task automatic send(input int x, input int y);
    iSAMPLE_VALID = 1'b1; iX_RAW = 12'(x); iY_RAW = 12'(y);
    tick(1);
    iSAMPLE_VALID = 1'b0;
  endtask

  task automatic send4(input int x, input int y);
    for (int i = 0; i < 4; i++) send(x, y);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    iAVS_READ = 1'b1; iAVS_ADDRESS = a;
    tick(1);
    iAVS_READ = 1'b0;
    d = oAVS_READDATA;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    iAVS_WRITE = 1'b1; iAVS_ADDRESS = a; iAVS_WRITEDATA = d;
    tick(1);
    iAVS_WRITE = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (oVALID) begin seen = 1; break; end
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit seen;
    int v0;
    iRST_n = 1'b0; iSAMPLE_VALID = 1'b0; iX_RAW = '0; iY_RAW = '0;
    iPENIRQ_n = 1'b0; iAVS_ADDRESS = '0; iAVS_READ = 1'b0; iAVS_WRITE = 1'b0;
    iAVS_WRITEDATA = '0;
    tick(3);
    check("reset_outputs", {oAVS_READDATA[20:0], oX_PIX}, 32'd0);
    check("reset_flags", {29'b0, oIRQ, oVALID, oTOUCHED}, 32'd0);
    iRST_n = 1'b1;
    tick(2);

    // Centre of screen, latency of exactly 3 cycles after the 4th strobe.
    send4(2050, 2050);
    tick(1); check("lat_c1", 32'(oVALID), 32'd0);
    tick(1); check("lat_c2", 32'(oVALID), 32'd0);
    tick(1); check("lat_c3", 32'(oVALID), 32'd1);
    check("centre_x", 32'(oX_PIX), 32'd400);
    check("centre_y", 32'(oY_PIX), 32'd240);
    check("centre_touched", 32'(oTOUCHED), 32'd1);

    // Status read clears new_flag; then enable the interrupt.
    rd(2'd0, d); check("status_a", d, 32'h3);
    wr(2'd0, 32'h4);
    tick(1); check("irq_idle", 32'(oIRQ), 32'd0);

    // Clamping corners plus interrupt handshake.
    send4(100, 4000);
    wait_valid("corner_valid");
    check("clamp_x0", 32'(oX_PIX), 32'd0);
    check("clamp_ymax", 32'(oY_PIX), 32'd479);
    tick(1); check("irq_set", 32'(oIRQ), 32'd1);
    rd(2'd0, d); check("status_b", d, 32'h7);
    check("irq_hold", 32'(oIRQ), 32'd1);
    tick(1); check("irq_clear", 32'(oIRQ), 32'd0);
    rd(2'd1, d); check("reg_x", d, 32'd0);
    rd(2'd2, d); check("reg_y", d, 32'd479);
    rd(2'd3, d); check("reg_avg", d, 32'h0FA0_0064);

    // Pen release after a report.
    iPENIRQ_n = 1'b1;
    seen = 0;
    for (int i = 0; i < REL + 20; i++) begin
      tick(1);
      if (!oTOUCHED) begin seen = 1; break; end
    end
    check("release_seen", 32'(seen), 32'd1);
    rd(2'd0, d); check("status_release", d, 32'h5);

    // Partial burst discarded by a second release.
    iPENIRQ_n = 1'b0;
    tick(4);
    v0 = vcount;
    send(100, 4000);
    send(100, 4000);
    iPENIRQ_n = 1'b1;
    tick(REL + 20);
    check("partial_no_report", 32'(vcount - v0), 32'd0);
    rd(2'd0, d); check("status_release2", d, 32'h5);
    iPENIRQ_n = 1'b0;
    tick(4);
    send4(2050, 2050);
    wait_valid("after_release_valid");
    check("after_release_x", 32'(oX_PIX), 32'd400);
    check("after_release_y", 32'(oY_PIX), 32'd240);

    // Asynchronous reset in the middle of a burst.
    send(3000, 1000);
    send(3000, 1000);
    @(posedge iCLK); #3;
    iRST_n = 1'b0;
    #1;
    check("async_rst_pix", {10'b0, oX_PIX, oY_PIX}, 32'd0);
    check("async_rst_flags", {29'b0, oIRQ, oVALID, oTOUCHED}, 32'd0);
    check("async_rst_rdata", oAVS_READDATA, 32'd0);
    @(posedge iCLK); #1;
    iRST_n = 1'b1;
    tick(1);
    send4(3000, 1000);
    wait_valid("post_rst_valid");
    check("post_rst_x", 32'(oX_PIX), 32'd605);
    check("post_rst_y", 32'(oY_PIX), 32'd96);

`ifdef TOUCH_OUTLIER_REJECT_EN
    tick(2);
    v0 = vcount;
    send(2000, 2000);
    send(2010, 2010);
    send(2500, 2500);
    send(2500, 2500);
    send(2500, 2500);
    send(2500, 2500);
    tick(6);
    check("outlier_reports", 32'(vcount - v0), 32'd1);
    check("outlier_x", 32'(oX_PIX), 32'd497);
    check("outlier_y", 32'(oY_PIX), 32'd301);
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/touch_coord_filter.md
Name: touch_coord_filter

Overview:
- Downstream consumer of the touchscreen ADC controller's raw 12-bit X/Y samples and its per-conversion strobe.
- Averages 2^AVG_LOG2 consecutive samples and detects pen release.
- Maps averaged raw values to clamped LCD pixel coordinates.
- Presents results to the Nios II through a small Avalon-MM slave with a level interrupt.

Parameters:
- AVG_LOG2, 2: log2 of samples averaged per report (legal 0..4).
- X_MIN, 200: raw X value mapped to pixel 0.
- Y_MIN, 300: raw Y value mapped to pixel 0.
- X_GAIN, 886: X scale, Q0.12 (pixels per raw LSB × 4096).
- Y_GAIN, 562: Y scale, Q0.12.
- H_RES, 800: horizontal pixel count; X clamps to H_RES-1.
- V_RES, 480: vertical pixel count; Y clamps to V_RES-1.
- RELEASE_CYC, 50000: consecutive iCLK cycles of synchronised pen-up that declare release.
- JITTER_MAX, 64: outlier threshold in raw LSB (optional feature only).

Ports:
- iCLK  in  1  system clock
- iRST_n  in  1  asynchronous active-low reset
- iSAMPLE_VALID  in  1  one-cycle strobe; iX_RAW/iY_RAW stable that cycle
- iX_RAW  in  12  raw X sample
- iY_RAW  in  12  raw Y sample
- iPENIRQ_n  in  1  pen-down from panel, asynchronous, active low
- iAVS_ADDRESS  in  2  Avalon word address
- iAVS_READ  in  1  Avalon read
- iAVS_WRITE  in  1  Avalon write
- iAVS_WRITEDATA  in  32  Avalon write data
- oAVS_READDATA  out  32  Avalon read data, registered
- oIRQ  out  1  level interrupt to CPU
- oX_PIX  out  11  last reported X pixel
- oY_PIX  out  11  last reported Y pixel
- oVALID  out  1  one-cycle pulse per new report
- oTOUCHED  out  1  pen currently considered down

Behaviour:
- Reset (iRST_n low, async): all outputs 0; accumulators and counters 0; irq_en=0; new_flag=0; FSM IDLE.
- iPENIRQ_n: passed through a 2-FF synchroniser before any use.
- FSM IDLE: on iSAMPLE_VALID, load accumulators with the sample, count=1 → ACCUM. If AVG_LOG2=0, go directly to SCALE.
- FSM ACCUM: each iSAMPLE_VALID adds to 16-bit X/Y accumulators and increments count. On the 2^AVG_LOG2-th sample → SCALE.
- FSM SCALE:
  - Cycle 1: avg = acc >> AVG_LOG2; diff = avg - MIN as signed 13-bit.
  - Cycle 2: product = diff × GAIN, registered.
  - Cycle 3: pix = product >> 12; clamp negative to 0 and ≥RES to RES-1; register oX_PIX/oY_PIX; pulse oVALID; set new_flag; set oTOUCHED → IDLE.
  - Latency: oVALID is high 3 cycles after the strobe cycle of the final sample.
  - iSAMPLE_VALID arriving during SCALE is dropped.
- Release detection:
  - A counter increments while synchronised pen is up and clears when it is down.
  - On reaching RELEASE_CYC: oTOUCHED←0, set new_flag, discard partial accumulation, FSM → IDLE. SCALE in progress still completes first.
  - Counter saturates; no repeat event until the pen goes down again.
- Avalon register map (read latency 1):
  - Address 0, status: bit0 new_flag, bit1 oTOUCHED, bit2 irq_en. A read clears new_flag; a set in the same cycle wins.
  - Address 1: oX_PIX.
  - Address 2: oY_PIX.
  - Address 3: {4'b0, avgY[11:0], 4'b0, avgX[11:0]}.
  - Write to address 0: bit2 → irq_en. Writes to other addresses are ignored.
- oIRQ = new_flag & irq_en, registered.

Optional Feature:
- TOUCH_OUTLIER_REJECT_EN defined: in ACCUM, a sample with |x − first_x| or |y − first_y| > JITTER_MAX aborts the burst. Accumulators reload with that sample and count=1.
- TOUCH_OUTLIER_REJECT_EN undefined: every sample is accepted and JITTER_MAX is unused.

Decomposition:
- Package touch_pkg holds:
  - FSM state encoding (IDLE, ACCUM, SCALE).
  - Register address constants.
  - Status bit indices.
- One sub-module, touch_axis_scale: the 3-stage avg/offset/multiply/clamp pipe. It is instantiated twice, once for X and once for Y, with MIN/GAIN/RES parameters.

Test Plan:
- 4 strobes with X=2050, Y=2050 → oX_PIX=400, oY_PIX=240; oVALID 3 cycles after the 4th strobe.
- 4 strobes with X=100, Y=4000 → oX_PIX=0, oY_PIX=479.
- irq_en=1 and a report completes → oIRQ=1; status read returns 0x7; oIRQ=0 two cycles later.
- After a report, hold iPENIRQ_n high 50000 cycles → oTOUCHED=0, new_flag=1. Two strobes then pen-up release → no oVALID.
- Assert iRST_n low mid-ACCUM → all outputs 0 immediately; the next 4 strobes give a clean report.
- With TOUCH_OUTLIER_REJECT_EN: strobes X=2000, 2010, 2500, 2500, 2500, 2500 → a single report based on 2500.
